// File: rtl/opr_pkg.sv
// Shared definitions for the operand-address generator: mode encodings,
// MOVI opcode, FSM state encoding and the displacement sign-extension helper.
package opr_pkg;

    localparam logic [1:0] MODE_REG = 2'b00;
    localparam logic [1:0] MODE_MOD = 2'b01;
    localparam logic [1:0] MODE_RAD = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam logic [3:0] OPC_MOVI = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_PTR = 3'd1,
        S_CALC   = 3'd2,
        S_OUT    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // 4-bit two's-complement displacement widened to 32 bits; callers keep the low DATA_W bits.
    function automatic logic [31:0] sext_disp(input logic [3:0] d);
        return {{28{d[3]}}, d};
    endfunction

endpackage

// File: rtl/opr_field_dec.sv
// Combinational IR/MODE field decoder: register selects, byte/word and
// high/low flags, pointer index, plus which of those a mode is allowed to update.
module opr_field_dec
    import opr_pkg::*;
#(
    parameter int IR_W = 16,
    parameter int RA_W = 1
) (
    input  logic [IR_W-1:0] ir,
    input  logic [1:0]      mode,
    output logic [RA_W-1:0] ra,
    output logic [RA_W-1:0] rb,
    output logic [RA_W-1:0] ptr,
    output logic            hl,
    output logic            wbr,
    output logic            sel_upd,
    output logic            wbr_upd,
    output logic            err
);

    localparam int K = RA_W;

    logic unused_ir;
    assign unused_ir = ^ir;

    always_comb begin
        ra      = '0;
        rb      = '0;
        hl      = 1'b0;
        wbr     = 1'b0;
        sel_upd = 1'b0;
        wbr_upd = 1'b0;
        err     = 1'b0;
        ptr     = ir[0+:K];
        case (mode)
            MODE_REG: begin
                sel_upd = 1'b1;
                wbr_upd = 1'b1;
                // MOVI carries its register fields in the upper byte
                if (ir[IR_W-1-:4] == OPC_MOVI) begin
                    rb  = ir[8+:K];
                    ra  = ir[8+K+:K];
                    hl  = ir[8+2*K];
                    wbr = ir[9+2*K];
                end else begin
                    rb  = ir[3+:K];
                    ra  = ir[3+K+:K];
                    hl  = ir[3+2*K];
                    wbr = ir[8];
                end
            end
            MODE_MOD: begin
                sel_upd = 1'b1;
                wbr_upd = 1'b1;
                rb      = ir[0+:K];
                ra      = ir[K+:K];
                hl      = ir[2*K];
                wbr     = ir[8];
            end
            MODE_RAD: begin
                wbr_upd = 1'b1;
                wbr     = ir[8];
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/opr_addr_gen.sv
// Operand-address generator: decodes IR fields per addressing mode and resolves
// register-indirect addresses. Optional pointer post-increment: OPR_POST_INC_EN.
module opr_addr_gen
    import opr_pkg::*;
#(
    parameter int IR_W   = 16,
    parameter int RA_W   = 1,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [IR_W-1:0]   IR,
    input  logic [1:0]        MODE,
    input  logic              REQ,
    output logic              ACK,
    output logic [RA_W-1:0]   RA,
    output logic [RA_W-1:0]   RB,
    output logic [RA_W-1:0]   WA,
    output logic [RA_W-1:0]   WB,
    output logic              W_B_R,
    output logic              H_L_R,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic              ERR,
    output logic              OUT_VLD,
    input  logic              OUT_RDY,
    output logic              RF_RD_EN,
    output logic [RA_W-1:0]   RF_RD_ADDR,
    input  logic [DATA_W-1:0] RF_RD_DATA,
    output logic              RF_WR_EN,
    output logic [RA_W-1:0]   RF_WR_ADDR,
    output logic [DATA_W-1:0] RF_WR_DATA
);

    state_t            state_q, state_nxt;
    logic [IR_W-1:0]   ir_q;
    logic [RA_W-1:0]   ra_q, rb_q, ptr_q;
    logic              hl_q, wbr_q, err_q, ack_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [31:0]       disp_ext;
    logic              accept, wb_pending;

    logic [RA_W-1:0] d_ra, d_rb, d_ptr;
    logic            d_hl, d_wbr, d_sel_upd, d_wbr_upd, d_err;

    opr_field_dec #(.IR_W(IR_W), .RA_W(RA_W)) u_dec (
        .ir      (IR),
        .mode    (MODE),
        .ra      (d_ra),
        .rb      (d_rb),
        .ptr     (d_ptr),
        .hl      (d_hl),
        .wbr     (d_wbr),
        .sel_upd (d_sel_upd),
        .wbr_upd (d_wbr_upd),
        .err     (d_err)
    );

    assign accept   = REQ && ack_q;
    assign disp_ext = sext_disp(ir_q[7:4]);

    logic unused_bits;
    assign unused_bits = ^{ir_q, disp_ext};

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_nxt = (MODE == MODE_RAD) ? S_RD_PTR : S_OUT;
            S_RD_PTR: state_nxt = S_CALC;
            S_CALC:   state_nxt = S_OUT;
            S_OUT:    if (OUT_RDY) state_nxt = wb_pending ? S_WB : S_IDLE;
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ACK is registered so it reads 0 while reset is held and rises on the first edge after release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ack_q   <= (state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            ptr_q      <= '0;
            hl_q       <= 1'b0;
            wbr_q      <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            if (accept) begin
                ir_q  <= IR;
                ptr_q <= d_ptr;
                err_q <= d_err;
                if (d_sel_upd) begin
                    ra_q <= d_ra;
                    rb_q <= d_rb;
                    hl_q <= d_hl;
                end
                if (d_wbr_upd) wbr_q <= d_wbr;
            end
            if (state_q == S_CALC) mem_addr_q <= RF_RD_DATA + disp_ext[DATA_W-1:0];
        end
    end

`ifdef OPR_POST_INC_EN
    logic              pinc_q;
    logic [DATA_W-1:0] ptr_val_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pinc_q    <= 1'b0;
            ptr_val_q <= '0;
        end else begin
            if (accept) pinc_q <= (MODE == MODE_RAD) && IR[3];
            if (state_q == S_CALC) ptr_val_q <= RF_RD_DATA;
        end
    end

    assign wb_pending = pinc_q;
    assign RF_WR_EN   = (state_q == S_WB);
    assign RF_WR_ADDR = RF_WR_EN ? ptr_q : '0;
    // step size follows the access width of this operation
    assign RF_WR_DATA = RF_WR_EN ? (ptr_val_q + (wbr_q ? DATA_W'(2) : DATA_W'(1))) : '0;
`else
    assign wb_pending = 1'b0;
    assign RF_WR_EN   = 1'b0;
    assign RF_WR_ADDR = '0;
    assign RF_WR_DATA = '0;
`endif

    assign ACK        = ack_q;
    assign RA         = ra_q;
    assign WA         = ra_q;
    assign RB         = rb_q;
    assign WB         = rb_q;
    assign W_B_R      = wbr_q;
    assign H_L_R      = hl_q;
    assign MEM_ADDR   = mem_addr_q;
    assign ERR        = err_q;
    assign OUT_VLD    = (state_q == S_OUT);
    assign RF_RD_EN   = (state_q == S_RD_PTR);
    assign RF_RD_ADDR = RF_RD_EN ? ptr_q : '0;

endmodule

// File: tb/tb_opr_addr_gen.sv
// Scoreboard bench for opr_addr_gen: directed requests push expected outputs,
// a monitor pops and compares on every OUT_VLD/OUT_RDY handshake.
module tb_opr_addr_gen;

    localparam int IR_W   = 16;
    localparam int RA_W   = 1;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IR_W-1:0]   ir;
    logic [1:0]        mode;
    logic              req;
    logic              ack;
    logic [RA_W-1:0]   ra, rb, wa, wb;
    logic              w_b_r, h_l_r;
    logic [DATA_W-1:0] mem_addr;
    logic              err, out_vld, out_rdy;
    logic              rf_rd_en;
    logic [RA_W-1:0]   rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_en;
    logic [RA_W-1:0]   rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    typedef struct packed {
        logic [RA_W-1:0]   ra;
        logic [RA_W-1:0]   rb;
        logic              hl;
        logic              wbr;
        logic              err;
        logic [DATA_W-1:0] mem;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic [63:0] outs;

    opr_addr_gen #(.IR_W(IR_W), .RA_W(RA_W), .DATA_W(DATA_W)) dut (
        .CLK(clk), .RST_N(rst_n), .IR(ir), .MODE(mode), .REQ(req), .ACK(ack),
        .RA(ra), .RB(rb), .WA(wa), .WB(wb), .W_B_R(w_b_r), .H_L_R(h_l_r),
        .MEM_ADDR(mem_addr), .ERR(err), .OUT_VLD(out_vld), .OUT_RDY(out_rdy),
        .RF_RD_EN(rf_rd_en), .RF_RD_ADDR(rf_rd_addr), .RF_RD_DATA(rf_rd_data),
        .RF_WR_EN(rf_wr_en), .RF_WR_ADDR(rf_wr_addr), .RF_WR_DATA(rf_wr_data)
    );

    initial forever #5 clk = ~clk;

    assign outs = 64'({ack, out_vld, ra, rb, wa, wb, w_b_r, h_l_r, mem_addr, err,
                       rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [RA_W-1:0] e_ra, input logic [RA_W-1:0] e_rb,
                                input logic e_hl, input logic e_wbr, input logic e_err,
                                input logic [DATA_W-1:0] e_mem);
        exp_t e;
        e.ra = e_ra; e.rb = e_rb; e.hl = e_hl; e.wbr = e_wbr; e.err = e_err; e.mem = e_mem;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns 1 time unit after the accepting edge.
    task automatic do_req(input logic [IR_W-1:0] t_ir, input logic [1:0] t_mode,
                          input exp_t e, input bit push);
        int n = 0;
        ir = t_ir; mode = t_mode; req = 1'b1;
        while (ack !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ack !== 1'b1) begin
            n_tot++;
            $display("FAIL accept_timeout: ACK=%b want 1", ack);
            req = 1'b0;
            return;
        end
        if (push) exp_q.push_back(e);
        step();
        req = 1'b0;
    endtask

    // Monitor: compare every completed output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_out: got OUT_VLD=1 want no pending output");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sel",   64'({ra, wa, rb, wb}), 64'({e.ra, e.ra, e.rb, e.rb}));
                    chk("out_flags", 64'({w_b_r, h_l_r, err}), 64'({e.wbr, e.hl, e.err}));
                    chk("out_mem",   64'(mem_addr), 64'(e.mem));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish want finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ir = '0; mode = 2'b00; req = 1'b0; out_rdy = 1'b1; rf_rd_data = '0;
        @(negedge clk);
        chk("reset_outs", outs, 64'd0);
        step();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ack_after_reset", 64'(ack), 64'd1);

        // MOVI in REG mode
        step();
        do_req(16'hB600, 2'b00, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000), 1'b1);
        @(negedge clk);
        chk("reg_vld_lat", 64'({out_vld, ack}), 64'(2'b10));
        @(negedge clk);
        chk("reg_ack_back", 64'({out_vld, ack}), 64'(2'b01));

        // Modifier mode with a 5-cycle consumer stall
        step();
        out_rdy = 1'b0;
        do_req(16'h0105, 2'b01, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mod_stall", 64'({out_vld, ack, ra, rb, h_l_r, w_b_r}),
                64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}));
        end
        step();
        out_rdy = 1'b1;
        @(negedge clk);

        // RAD: pointer 0x0010, displacement -1
        step();
        rf_rd_data = 16'h0010;
        do_req(16'h01F1, 2'b10, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h000F), 1'b1);
        @(negedge clk);
        chk("rad_rd_pulse", 64'({rf_rd_en, rf_rd_addr, out_vld}), 64'({1'b1, 1'b1, 1'b0}));
        @(negedge clk);
        chk("rad_calc", 64'({rf_rd_en, out_vld}), 64'd0);
        @(negedge clk);
        chk("rad_vld_lat", 64'(out_vld), 64'd1);
        @(negedge clk);
        chk("rad_no_wb", 64'({rf_wr_en, ack}), 64'(2'b01));

        // RAD wrap: pointer 0xFFFC, displacement +7, word access, post-increment bit set
        step();
        rf_rd_data = 16'hFFFC;
        do_req(16'h0178, 2'b10, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0003), 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_vld_lat", 64'(out_vld), 64'd1);
        @(negedge clk);
`ifdef OPR_POST_INC_EN
        chk("wb_pulse", 64'({rf_wr_en, rf_wr_addr, rf_wr_data, ack}),
            64'({1'b1, 1'b0, 16'hFFFE, 1'b0}));
`else
        chk("wb_pulse", 64'({rf_wr_en, rf_wr_addr, rf_wr_data, ack}),
            64'({1'b0, 1'b0, 16'h0000, 1'b1}));
`endif
        @(negedge clk);
        chk("wb_done", 64'({rf_wr_en, ack}), 64'(2'b01));

        // reserved mode holds selects and flags ERR; next REG accept clears it
        step();
        do_req(16'h0FFF, 2'b11, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003), 1'b1);
        @(negedge clk);
        chk("rsv_err", 64'({out_vld, err}), 64'(2'b11));
        step();
        do_req(16'h0130, 2'b00, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0003), 1'b1);
        @(negedge clk);
        chk("err_clear", 64'({out_vld, err}), 64'(2'b10));

        // reset asserted during RD_PTR aborts the post-increment operation
        step();
        rf_rd_data = 16'h0010;
        do_req(16'h01F9, 2'b10, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000), 1'b0);
        chk("rst_in_rdptr", 64'(rf_rd_en), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_abort", outs, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", 64'({rf_wr_en, out_vld, ack}), 64'd0);
        end
        step();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ack_after_abort", 64'({ack, rf_wr_en, out_vld}), 64'(3'b100));

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
